// File: rtl/lane_fifo_pkg.sv
// rtl/lane_fifo_pkg.sv - shared constants, width helpers and mask type for lane_fifo_array
// Default lane count follows the global data bus width when one is provided.
`ifndef PAR_GLB_DATA_BITS
`define PAR_GLB_DATA_BITS 64
`endif

package lane_fifo_pkg;
   localparam int LANE_BITS_DFLT = 16;
   localparam int LANES_DFLT     = `PAR_GLB_DATA_BITS / 16;
   localparam int DEPTH_DFLT     = 4;

   typedef logic [LANES_DFLT-1:0] lane_mask_t;

   function automatic int ptr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int level_bits(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/lane_fifo_array_if.sv
// rtl/lane_fifo_array_if.sv - write/read handshake bundle of lane_fifo_array
// LANE_FIFO_STALL_CNT_EN adds the stall counter output to the bundle.
interface lane_fifo_array_if
   import lane_fifo_pkg::*;
#(
   parameter int LANE_BITS = LANE_BITS_DFLT,
   parameter int LANES     = LANES_DFLT,
   parameter int DEPTH     = DEPTH_DFLT
);
   localparam int LW = level_bits(DEPTH);

   logic [LANES*LANE_BITS-1:0] ivG_data;
   logic [LANES-1:0]           ivG_lane_en;
   logic                       ib_valid;
   logic                       ob_ready;
   logic [LANES*LANE_BITS-1:0] ovG_data;
   logic                       ob_valid;
   logic                       ib_ready;
   logic [LW-1:0]              ovG_level;

`ifdef LANE_FIFO_STALL_CNT_EN
   logic [15:0]                ovG_stall_cnt;

   modport master (output ivG_data, ivG_lane_en, ib_valid, ib_ready,
                   input  ob_ready, ovG_data, ob_valid, ovG_level, ovG_stall_cnt);
   modport slave  (input  ivG_data, ivG_lane_en, ib_valid, ib_ready,
                   output ob_ready, ovG_data, ob_valid, ovG_level, ovG_stall_cnt);
`else
   modport master (output ivG_data, ivG_lane_en, ib_valid, ib_ready,
                   input  ob_ready, ovG_data, ob_valid, ovG_level);
   modport slave  (input  ivG_data, ivG_lane_en, ib_valid, ib_ready,
                   output ob_ready, ovG_data, ob_valid, ovG_level);
`endif
endinterface

// File: rtl/lane_fifo_slice.sv
// rtl/lane_fifo_slice.sv - one lane of storage plus its per-entry enable bit
// Payload is only overwritten for enabled lanes; the mask bit is written on every push.
module lane_fifo_slice
   import lane_fifo_pkg::*;
#(
   parameter int LANE_BITS = LANE_BITS_DFLT,
   parameter int DEPTH     = DEPTH_DFLT
) (
   input  logic                          ib_clk,
   input  logic                          we_i,
   input  logic                          lane_en_i,
   input  logic [ptr_bits(DEPTH)-1:0]    wr_ptr_i,
   input  logic [ptr_bits(DEPTH)-1:0]    rd_ptr_i,
   input  logic [LANE_BITS-1:0]          data_i,
   output logic [LANE_BITS-1:0]          data_o
);
   logic [LANE_BITS-1:0] mem_q  [DEPTH];
   logic                 mask_q [DEPTH];

   always_ff @(posedge ib_clk) begin
      if (we_i) begin
         mask_q[wr_ptr_i] <= lane_en_i;
         if (lane_en_i) begin
            mem_q[wr_ptr_i] <= data_i;
         end
      end
   end

   assign data_o = mask_q[rd_ptr_i] ? mem_q[rd_ptr_i] : '0;
endmodule

// File: rtl/lane_fifo_array.sv
// rtl/lane_fifo_array.sv - multi-lane FIFO: shared pointers, level, run flag and handshake
// LANE_FIFO_STALL_CNT_EN adds a saturating count of stalled write requests.
module lane_fifo_array
   import lane_fifo_pkg::*;
#(
   parameter int PAR_LANE_BITS = LANE_BITS_DFLT,
   parameter int PAR_LANES     = LANES_DFLT,
   parameter int PAR_DEPTH     = DEPTH_DFLT
) (
   input  logic              ib_clk,
   input  logic              ib_rst_n,
   lane_fifo_array_if.slave  bus
);
   localparam int PW = ptr_bits(PAR_DEPTH);
   localparam int LW = level_bits(PAR_DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          run_q;
   logic          ready, valid, wr_fire, rd_fire;
   logic [PAR_LANES*PAR_LANE_BITS-1:0] head;

   // Ready depends only on registered state so a same-cycle read never opens a write slot.
   assign ready   = run_q & (level_q != LW'(PAR_DEPTH));
   assign valid   = (level_q != '0);
   assign wr_fire = bus.ib_valid & ready;
   assign rd_fire = bus.ib_ready & valid;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_fire, rd_fire})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge ib_clk or negedge ib_rst_n) begin
      if (!ib_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         run_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         run_q    <= 1'b1;
      end
   end

   for (genvar k = 0; k < PAR_LANES; k++) begin : g_lane
      lane_fifo_slice #(
         .LANE_BITS (PAR_LANE_BITS),
         .DEPTH     (PAR_DEPTH)
      ) u_slice (
         .ib_clk    (ib_clk),
         .we_i      (wr_fire),
         .lane_en_i (bus.ivG_lane_en[k]),
         .wr_ptr_i  (wr_ptr_q),
         .rd_ptr_i  (rd_ptr_q),
         .data_i    (bus.ivG_data[k*PAR_LANE_BITS +: PAR_LANE_BITS]),
         .data_o    (head[k*PAR_LANE_BITS +: PAR_LANE_BITS])
      );
   end

   assign bus.ob_ready  = ready;
   assign bus.ob_valid  = valid;
   assign bus.ovG_level = level_q;
   assign bus.ovG_data  = valid ? head : '0;

`ifdef LANE_FIFO_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (run_q & bus.ib_valid & ~ready & (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge ib_clk or negedge ib_rst_n) begin
      if (!ib_rst_n) stall_q <= '0;
      else           stall_q <= stall_d;
   end

   assign bus.ovG_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_lane_fifo_array.sv
// tb/tb_lane_fifo_array.sv - directed table, corner sequences and random traffic vs a queue model
// LANE_FIFO_STALL_CNT_EN also checks the stall counter.
module tb_lane_fifo_array;
   localparam int LB    = 16;
   localparam int LANES = 4;
   localparam int DEPTH = 4;

   logic ib_clk   = 1'b0;
   logic ib_rst_n = 1'b0;

   lane_fifo_array_if #(.LANE_BITS(LB), .LANES(LANES), .DEPTH(DEPTH)) bus ();

   lane_fifo_array #(.PAR_LANE_BITS(LB), .PAR_LANES(LANES), .PAR_DEPTH(DEPTH)) dut (
      .ib_clk   (ib_clk),
      .ib_rst_n (ib_rst_n),
      .bus      (bus)
   );

   always #5 ib_clk = ~ib_clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [63:0] m_q[$];
   logic        m_run;
   logic [15:0] m_stall;

   typedef struct {
      logic        v;
      logic [63:0] d;
      logic [3:0]  en;
      logic        r;
      logic        e_rdy;
      logic        e_vld;
      logic [63:0] e_data;
      logic [2:0]  e_lvl;
   } vec_t;
   vec_t tbl[20];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] mask_word(input logic [63:0] d, input logic [3:0] en);
      logic [63:0] m;
      m = '0;
      for (int k = 0; k < LANES; k++)
         if (en[k]) m[k*LB +: LB] = d[k*LB +: LB];
      return m;
   endfunction

   task automatic check_model(input string nm);
      logic [63:0] head;
      head = (m_q.size() != 0) ? m_q[0] : 64'h0;
      chk({nm, ".ready"}, 64'(bus.ob_ready), 64'(m_run && (m_q.size() < DEPTH)));
      chk({nm, ".valid"}, 64'(bus.ob_valid), 64'(m_q.size() != 0));
      chk({nm, ".data"},  bus.ovG_data, head);
      chk({nm, ".level"}, 64'(bus.ovG_level), 64'(m_q.size()));
`ifdef LANE_FIFO_STALL_CNT_EN
      chk({nm, ".stall"}, 64'(bus.ovG_stall_cnt), 64'(m_stall));
`endif
   endtask

   // Called at a falling edge; applies inputs across one rising edge and checks at the next fall.
   task automatic step(input string nm, input logic v, input logic [63:0] d,
                       input logic [3:0] en, input logic r);
      logic m_rdy, wr, rd;
      bus.ib_valid = v; bus.ivG_data = d; bus.ivG_lane_en = en; bus.ib_ready = r;
      m_rdy = m_run && (m_q.size() < DEPTH);
      wr = v && m_rdy;
      rd = r && (m_q.size() != 0);
      if (m_run && v && !m_rdy && m_stall != 16'hFFFF) m_stall++;
      @(posedge ib_clk);
      if (rd) void'(m_q.pop_front());
      if (wr) m_q.push_back(mask_word(d, en));
      m_run = 1'b1;
      @(negedge ib_clk);
      check_model(nm);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_run   = 1'b0;
      m_stall = '0;
   endtask

   task automatic release_reset();
      ib_rst_n = 1'b1;
      #1;
      chk("rel.ready_before_edge", 64'(bus.ob_ready), 64'h0);
      @(negedge ib_clk);
      bus.ib_valid = 1'b0;
      step("rel.first_edge", 1'b0, 64'h0, 4'h0, 1'b0);
   endtask

   initial begin
      bus.ib_valid = 1'b0; bus.ib_ready = 1'b0; bus.ivG_data = '0; bus.ivG_lane_en = '0;
      model_reset();

      tbl[0]  = '{1'b1, 64'h4444_3333_2222_1111, 4'hF, 1'b0, 1'b1, 1'b1, 64'h4444_3333_2222_1111, 3'd1};
      tbl[1]  = '{1'b0, 64'h0, 4'h0, 1'b1, 1'b1, 1'b0, 64'h0, 3'd0};
      tbl[2]  = '{1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 4'h5, 1'b0, 1'b1, 1'b1, 64'h0000_CCCC_0000_AAAA, 3'd1};
      tbl[3]  = '{1'b0, 64'h0, 4'h0, 1'b1, 1'b1, 1'b0, 64'h0, 3'd0};
      tbl[4]  = '{1'b1, 64'h1001_1002_1003_1004, 4'hF, 1'b0, 1'b1, 1'b1, 64'h1001_1002_1003_1004, 3'd1};
      tbl[5]  = '{1'b1, 64'h2001_2002_2003_2004, 4'hF, 1'b0, 1'b1, 1'b1, 64'h1001_1002_1003_1004, 3'd2};
      tbl[6]  = '{1'b1, 64'h3001_3002_3003_3004, 4'hF, 1'b0, 1'b1, 1'b1, 64'h1001_1002_1003_1004, 3'd3};
      tbl[7]  = '{1'b1, 64'h4001_4002_4003_4004, 4'hF, 1'b0, 1'b0, 1'b1, 64'h1001_1002_1003_1004, 3'd4};
      tbl[8]  = '{1'b1, 64'h5001_5002_5003_5004, 4'hF, 1'b0, 1'b0, 1'b1, 64'h1001_1002_1003_1004, 3'd4};
      tbl[9]  = '{1'b1, 64'h5001_5002_5003_5004, 4'hF, 1'b1, 1'b1, 1'b1, 64'h2001_2002_2003_2004, 3'd3};
      tbl[10] = '{1'b0, 64'h0, 4'h0, 1'b1, 1'b1, 1'b1, 64'h3001_3002_3003_3004, 3'd2};
      tbl[11] = '{1'b0, 64'h0, 4'h0, 1'b1, 1'b1, 1'b1, 64'h4001_4002_4003_4004, 3'd1};
      tbl[12] = '{1'b0, 64'h0, 4'h0, 1'b1, 1'b1, 1'b0, 64'h0, 3'd0};
      tbl[13] = '{1'b1, 64'h6006_6006_6006_6006, 4'hF, 1'b0, 1'b1, 1'b1, 64'h6006_6006_6006_6006, 3'd1};
      tbl[14] = '{1'b1, 64'h7007_7007_7007_7007, 4'hF, 1'b1, 1'b1, 1'b1, 64'h7007_7007_7007_7007, 3'd1};
      tbl[15] = '{1'b1, 64'h8008_8008_8008_8008, 4'hF, 1'b1, 1'b1, 1'b1, 64'h8008_8008_8008_8008, 3'd1};
      tbl[16] = '{1'b1, 64'h9009_9009_9009_9009, 4'hF, 1'b1, 1'b1, 1'b1, 64'h9009_9009_9009_9009, 3'd1};
      tbl[17] = '{1'b0, 64'h0, 4'h0, 1'b1, 1'b1, 1'b0, 64'h0, 3'd0};
      tbl[18] = '{1'b1, 64'hFFFF_EEEE_DDDD_CCCC, 4'h0, 1'b0, 1'b1, 1'b1, 64'h0, 3'd1};
      tbl[19] = '{1'b0, 64'h0, 4'h0, 1'b1, 1'b1, 1'b0, 64'h0, 3'd0};

      // Reset state and release
      @(negedge ib_clk);
      @(negedge ib_clk);
      chk("rst.ready", 64'(bus.ob_ready), 64'h0);
      chk("rst.valid", 64'(bus.ob_valid), 64'h0);
      chk("rst.level", 64'(bus.ovG_level), 64'h0);
      chk("rst.data",  bus.ovG_data, 64'h0);
      release_reset();

      for (int i = 0; i < 20; i++) begin
         step($sformatf("tbl%0d", i), tbl[i].v, tbl[i].d, tbl[i].en, tbl[i].r);
         chk($sformatf("tbl%0d.ready", i), 64'(bus.ob_ready), 64'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d.valid", i), 64'(bus.ob_valid), 64'(tbl[i].e_vld));
         chk($sformatf("tbl%0d.data", i),  bus.ovG_data, tbl[i].e_data);
         chk($sformatf("tbl%0d.level", i), 64'(bus.ovG_level), 64'(tbl[i].e_lvl));
      end

      // Level held at 2 by simultaneous push and pop
      step("l2.w0", 1'b1, 64'hA0A0_0000_0000_0001, 4'hF, 1'b0);
      step("l2.w1", 1'b1, 64'hA0A0_0000_0000_0002, 4'hF, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step($sformatf("l2.rw%0d", i), 1'b1, {$urandom, $urandom}, 4'hF, 1'b1);
         chk($sformatf("l2.rw%0d.level2", i), 64'(bus.ovG_level), 64'h2);
      end
      for (int i = 0; i < 2; i++) step("l2.drain", 1'b0, 64'h0, 4'h0, 1'b1);

      // Asynchronous reset with three words stored
      for (int i = 0; i < 3; i++) step("ar.fill", 1'b1, 64'h0BAD_0000_0000_0000 + 64'(i), 4'hF, 1'b0);
      chk("ar.level3", 64'(bus.ovG_level), 64'h3);
      #2 ib_rst_n = 1'b0;
      #1;
      chk("ar.valid", 64'(bus.ob_valid), 64'h0);
      chk("ar.level", 64'(bus.ovG_level), 64'h0);
      chk("ar.ready", 64'(bus.ob_ready), 64'h0);
      chk("ar.data",  bus.ovG_data, 64'h0);
      model_reset();
      @(negedge ib_clk);
      release_reset();

`ifdef LANE_FIFO_STALL_CNT_EN
      for (int i = 0; i < DEPTH; i++) step("st.fill", 1'b1, 64'(i), 4'hF, 1'b0);
      for (int i = 0; i < 7; i++) step("st.stall", 1'b1, 64'h77, 4'hF, 1'b0);
      chk("st.cnt7", 64'(bus.ovG_stall_cnt), 64'd7);
      #2 ib_rst_n = 1'b0;
      #1;
      chk("st.cnt_rst", 64'(bus.ovG_stall_cnt), 64'd0);
      model_reset();
      @(negedge ib_clk);
      release_reset();
`endif

      // Random traffic: first half write-heavy, second half read-heavy
      for (int i = 0; i < 400; i++) begin
         logic v, r;
         if (i < 200) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) == 0);
         end else begin
            v = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
         end
         step($sformatf("rnd%0d", i), v, {$urandom, $urandom}, 4'($urandom), r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
